// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// step-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for a given step count; at least one bit so the
    // single-step configuration still has a legal vector.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from a chain of
// full-adder cells: {co, s} = a + b + ci.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: {Cout, Sum} = A + B + Cin, DIGIT bits per clock,
// with valid/ready handshakes on input and output.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a Sub input that turns
// the operation into A - B (computed as A + ~B + 1, Cin ignored).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(STEPS);

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;
    logic               accept;
    logic               sub_op;
    logic [DIGIT-1:0]   dsum;
    logic               dco;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_op = Sub;
`else
    assign sub_op = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(STEPS - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a  (a_sr[DIGIT-1:0]),
        .b  (b_sr[DIGIT-1:0]),
        .ci (carry),
        .s  (dsum),
        .co (dco)
    );

    // New digit enters at the MSB end; after STEPS shifts the LSB digit
    // computed first has reached bit 0.
    assign res_next = (res_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (last_step) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-step digit addition and result registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else begin
            if (accept) begin
                a_sr  <= A;
                b_sr  <= sub_op ? ~B : B;
                carry <= sub_op ? 1'b1 : Cin;
                cnt   <= '0;
            end else if (state == ST_BUSY) begin
                a_sr   <= a_sr >> DIGIT;
                b_sr   <= b_sr >> DIGIT;
                carry  <= dco;
                res_sr <= res_next;
                cnt    <= cnt + 1'b1;
                if (last_step) begin
                    Sum  <= res_next;
                    Cout <= dco;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven vectors on the
// DIGIT=1 instance plus hand sequences for backpressure, mid-operation
// reset and a DIGIT=4 instance.
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;

    logic       in_valid4;
    logic       in_ready4;
    logic [7:0] a4;
    logic [7:0] b4;
    logic       cin4;
    logic       sub4;
    logic       out_valid4;
    logic       out_ready4;
    logic [7:0] sum4;
    logic       cout4;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .Cout      (cout)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (a4),
        .B         (b4),
        .Cin       (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .Sum       (sum4),
        .Cout      (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on the DIGIT=1 instance with latency check.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b0;
        check($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, 8);
        check($sformatf("v%0d_sum", idx), sum, v.exp_sum);
        check($sformatf("v%0d_cout", idx), cout, v.exp_cout);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_back_idle", idx), in_ready, 1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

        //              a      b      cin   sub   sum    cout
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0});
        vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1});
`endif

        // Reset state
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result held in DONE, new input ignored.
        @(negedge clk);
        a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
            check($sformatf("bp%0d_sum", i), sum, 8'h77);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_idle_sum_kept", sum, 8'h77);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'hAA; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0}, 100);

        // DIGIT=4 instance: two steps per operation.
        @(negedge clk);
        a4 = 8'h3C; b4 = 8'h0F; cin4 = 1'b0; sub4 = 1'b0; in_valid4 = 1'b1;
        check("d4_in_ready", in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("d4_latency", lat, 2);
        check("d4_sum", sum4, 8'h4B);
        check("d4_cout", cout4, 0);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        @(negedge clk);
        a4 = 8'hF8; b4 = 8'h0F; cin4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("d4b_latency", lat, 2);
        check("d4b_sum", sum4, 8'h08);
        check("d4b_cout", cout4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
